// File: rtl/read_master.sv
// read_master
// Avalon-MM read master that fetches a block of 16-bit signed samples from
// DDR and replays them as a valid/ready stream. The block is configured and
// started through a small CSR slave. Reads are pipelined. A request is only
// issued while (FIFO occupancy + outstanding reads) is below FIFO_DEPTH, so
// every returned word always has room in the output FIFO.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   ddr_addr/ddr_read             DDR request (word address, read strobe)
//   ddr_waitrequest               DDR stall; the request holds while high
//   ddr_readdata/ddr_readdatavalid  DDR return data
//   csr_addr/read/write/writedata CSR slave; csr_readdata is registered
//   dout/dout_valid/dout_ready    output sample stream (show-ahead FIFO)
//
// CSR map: 0 base, 1 length, 2 step, 3 issued (RO), 4 start (W),
//          5 done bit 0 (RO), 6 soft reset (W), others read 0xDEADBEEF
//
// State | meaning
// IDLE  | waiting for start after reset
// RUN   | issuing reads until length requests have been accepted
// DRAIN | waiting for outstanding data to return and the FIFO to empty
// DONE  | block complete, done=1; a new start restarts
module read_master #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ddr_waitrequest,
  output logic [31:0] ddr_addr,
  output logic        ddr_read,
  input  logic [15:0] ddr_readdata,
  input  logic        ddr_readdatavalid,
  input  logic [2:0]  csr_addr,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [31:0] cfg_base, cfg_length, cfg_step;
  logic [31:0] len_w, step_w, issued;
  logic [CNT_W-1:0] outstanding, fifo_count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [15:0] mem [FIFO_DEPTH];
  logic [CNT_W:0] inflight;
  logic rst_int, start, load, accept, push, pop, fifo_empty, credit_ok;

  // A write to address 6 resets everything, including the CSR registers.
  assign rst_int = reset | (csr_write & (csr_addr == 3'd6));
  assign start   = csr_write & (csr_addr == 3'd4);

  assign inflight   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok  = inflight < DEPTH_C;
  assign fifo_empty = (fifo_count == '0);
  assign accept     = ddr_read & ~ddr_waitrequest;
  // Returns with nothing outstanding are stale data from before a soft reset.
  assign push       = ddr_readdatavalid & (outstanding != '0);
  assign pop        = dout_valid & dout_ready;

  assign dout_valid = ~fifo_empty;
  assign dout       = fifo_empty ? 16'd0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_int) state <= IDLE;
    else         state <= state_nxt;
  end

  // While stalled, issued is frozen and inflight can only fall, so ddr_read
  // cannot drop during waitrequest.
  always_comb begin
    state_nxt = state;
    ddr_read  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (cfg_length == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        ddr_read = (issued < len_w) & credit_ok;
        if (issued == len_w) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((outstanding == '0) && fifo_empty) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_int) begin
      cfg_base   <= 32'd0;
      cfg_length <= 32'd0;
      cfg_step   <= 32'd1;
    end else if (csr_write) begin
      case (csr_addr)
        3'd0: cfg_base   <= csr_writedata;
        3'd1: cfg_length <= csr_writedata;
        3'd2: cfg_step   <= csr_writedata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_int) begin
      ddr_addr <= 32'd0;
      issued   <= 32'd0;
      len_w    <= 32'd0;
      step_w   <= 32'd1;
    end else if (load) begin
      ddr_addr <= cfg_base;
      issued   <= 32'd0;
      len_w    <= cfg_length;
      step_w   <= cfg_step;
    end else if (accept) begin
      ddr_addr <= ddr_addr + step_w;
      issued   <= issued + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_int) begin
      outstanding <= '0;
    end else begin
      case ({accept, push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ddr_readdata;
  end

  always_ff @(posedge clk) begin
    if (rst_int) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_int) begin
      csr_readdata <= 32'd0;
    end else if (csr_read) begin
      case (csr_addr)
        3'd0:    csr_readdata <= cfg_base;
        3'd1:    csr_readdata <= cfg_length;
        3'd2:    csr_readdata <= cfg_step;
        3'd3:    csr_readdata <= issued;
        3'd5:    csr_readdata <= {31'd0, state == DONE};
        default: csr_readdata <= 32'hDEADBEEF;
      endcase
    end
  end

endmodule

// File: doc/read_master.md
Name: read_master

Overview:
Avalon-MM DDR3 read master that fetches a programmed block of 16-bit signed samples from DRAM and emits them as a valid/ready stream. It is the playback counterpart of the stream-to-DRAM writer. The block is configured and started over a small Avalon-MM CSR slave. Reads are pipelined, and outstanding requests are credit-limited so the internal output FIFO can never overflow.

Parameters:
FIFO_DEPTH, 8, output FIFO entries; also the cap on (FIFO occupancy + outstanding reads); power of 2, minimum 2
CNT_W, 4, width of the occupancy/outstanding counters; must hold FIFO_DEPTH

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ddr_waitrequest  in  1  DDR slave stall
ddr_addr  out  32  DDR word address
ddr_read  out  1  DDR read request
ddr_readdata  in  16  DDR read data (signed)
ddr_readdatavalid  in  1  DDR read data strobe
csr_addr  in  3  CSR word address
csr_read  in  1  CSR read strobe
csr_write  in  1  CSR write strobe
csr_writedata  in  32  CSR write data
csr_readdata  out  32  CSR read data, registered
dout  out  16  stream sample (signed)
dout_valid  out  1  stream valid
dout_ready  in  1  stream ready

Behaviour:
- Reset: clk and reset are as already decided (reset is synchronous, active-high, clock is clk).
- Soft reset: internal reset = reset OR (csr_write AND csr_addr==6).
- On reset: base=0, length=0, step=1, state=IDLE, ddr_read=0, ddr_addr=0, csr_readdata=0, done=0, FIFO empty (dout_valid=0, dout=0), issued=0, outstanding=0.
- CSR map:
  - 0: base (R/W).
  - 1: length in samples (R/W).
  - 2: step (R/W).
  - 3: issued count (RO).
  - 4: start (W).
  - 5: done, bit 0 (RO).
  - 6: soft reset (W).
  - 7 and unmapped reads return 0xDEADBEEF; writes there are ignored.
- CSR read timing: csr_readdata updates the cycle after csr_read, with no wait states.
- Config latching: base, length and step are copied into working registers on start. Later CSR writes do not affect a run in progress.
- State IDLE:
  - ddr_read=0.
  - On start: load ddr_addr=base, issued=0, clear done.
  - If length==0, go to DONE; otherwise go to RUN.
- State RUN:
  - Issue condition: ddr_read=1 when issued<length AND (fifo_count+outstanding)<FIFO_DEPTH.
  - Avalon hold rule: while ddr_read=1 and ddr_waitrequest=1, ddr_read and ddr_addr hold stable.
  - Accept = ddr_read AND NOT ddr_waitrequest. On accept: ddr_addr += step (32-bit wrap), issued++, outstanding++.
  - Deassert ddr_read on the cycle after the final accept or when credits run out; no extra request is ever issued.
  - When issued==length, go to DRAIN.
- State DRAIN:
  - ddr_read=0.
  - When outstanding==0 AND FIFO empty, go to DONE.
- State DONE:
  - done=1.
  - A start restarts as in IDLE.
  - Any other input holds DONE.
- Start while in RUN or DRAIN is ignored.
- Data return:
  - ddr_readdatavalid with outstanding>0 pushes ddr_readdata into the FIFO and decrements outstanding.
  - ddr_readdatavalid with outstanding==0 (late data after a soft reset) is discarded.
- FIFO:
  - Show-ahead: dout_valid = NOT empty, and dout is the head entry.
  - Pop when dout_valid AND dout_ready.
  - Simultaneous push and pop leaves the count unchanged and is legal when full.
  - Latency: data returned at cycle N appears on dout at cycle N+1.
- Overflow: cannot occur by construction of the credit rule; the bench asserts it never happens.
- Accept and data return in the same cycle: outstanding is unchanged.

Test Plan:
1. base=0x100, len=4, step=1, waitrequest=0, readdatavalid 2 cycles after each accept, dout_ready=1 -> reads issued at 0x100..0x103; dout carries the 4 returned words in order; done reads 1 at addr 5 after DRAIN; issued reads 4.
2. Same as 1 with waitrequest high for 3 cycles on the second request -> ddr_addr holds 0x101 and ddr_read stays 1 through the stall; exactly 4 accepts occur.
3. len=20, dout_ready=0 -> ddr_read drops after 8 accepts (FIFO_DEPTH); fifo_count=8 and dout_valid=1; raising dout_ready resumes issue; all 20 samples arrive in order.
4. len=0 then start -> no ddr_read; done=1 on the cycle after DONE is entered; dout_valid stays 0.
5. base=0x200, len=3, step=2 -> addresses 0x200, 0x202, 0x204; writing base=0 mid-run changes nothing; a start issued mid-run is ignored.
6. Soft reset (write addr 6) mid-RUN with 2 reads outstanding -> next cycle: ddr_read=0, FIFO empty, done=0, length=0, step=1; the 2 late readdatavalid pulses are discarded and dout_valid stays 0.
